// File: rtl/agc_quantize.sv
// Adaptive 2-bit {sign, mag} quantizer for one complex channel. The magnitude threshold
// is retuned once per window so the high-magnitude fraction stays inside [HI_LO, HI_HI].
module agc_quantize #(
    parameter int WINDOW_LOG2 = 12,
    parameter int HI_LO       = 2458,
    parameter int HI_HI       = 2949,
    parameter int THR_INIT    = 16,
    parameter int THR_MIN     = 1,
    parameter int THR_MAX     = 127
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic [7:0]             i_in,
    input  logic [7:0]             q_in,
    input  logic                   thr_load,
    input  logic [6:0]             thr_value,
    input  logic                   freeze,
    output logic [1:0]             si,
    output logic [1:0]             sq,
    output logic                   out_valid,
    output logic [6:0]             thr,
    output logic [WINDOW_LOG2+1:0] hi_count,
    output logic                   window_done
);

    localparam int CW = WINDOW_LOG2 + 2;
    localparam logic [CW-1:0] HI_LO_C    = CW'(HI_LO);
    localparam logic [CW-1:0] HI_HI_C    = CW'(HI_HI);
    localparam logic [6:0]    THR_INIT_C = 7'(THR_INIT);
    localparam logic [6:0]    THR_MIN_C  = 7'(THR_MIN);
    localparam logic [6:0]    THR_MAX_C  = 7'(THR_MAX);

    // One's-complement magnitude: -1 maps to 0 and -128 to 127, so it never overflows.
    function automatic logic [6:0] mag_of(input logic [7:0] x);
        return x[7] ? ~x[6:0] : x[6:0];
    endfunction

    function automatic logic [6:0] clamp_thr(input logic [6:0] v);
        if (v < THR_MIN_C)
            return THR_MIN_C;
        else if (v > THR_MAX_C)
            return THR_MAX_C;
        return v;
    endfunction

    logic [WINDOW_LOG2-1:0] cnt;
    logic [CW-1:0]          acc;
    logic                   mag_i_p0, mag_q_p0;
    logic [CW-1:0]          contrib_p0, total_p0;
    logic                   last_p0;
    logic [1:0]             si_p1, sq_p1;
    logic                   vld_p1;

    always_comb begin
        mag_i_p0   = (mag_of(i_in) >= thr);
        mag_q_p0   = (mag_of(q_in) >= thr);
        contrib_p0 = CW'(mag_i_p0) + CW'(mag_q_p0);
        total_p0   = acc + contrib_p0;
        last_p0    = (cnt == {WINDOW_LOG2{1'b1}});
    end

    // p0 -> p1: quantizer outputs, window statistics and threshold step share this edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            si_p1       <= 2'b00;
            sq_p1       <= 2'b00;
            vld_p1      <= 1'b0;
            thr         <= THR_INIT_C;
            hi_count    <= '0;
            window_done <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
        end else begin
            vld_p1      <= en;
            window_done <= 1'b0;
            if (en) begin
                si_p1 <= {i_in[7], mag_i_p0};
                sq_p1 <= {q_in[7], mag_q_p0};
            end
            // A load restarts the window and swallows any sample or window end on this edge.
            if (thr_load) begin
                thr <= clamp_thr(thr_value);
                cnt <= '0;
                acc <= '0;
            end else if (en) begin
                if (last_p0) begin
                    hi_count    <= total_p0;
                    window_done <= 1'b1;
                    cnt         <= '0;
                    acc         <= '0;
                    if (!freeze) begin
                        if (total_p0 > HI_HI_C && thr < THR_MAX_C)
                            thr <= thr + 7'd1;
                        else if (total_p0 < HI_LO_C && thr > THR_MIN_C)
                            thr <= thr - 7'd1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                    acc <= total_p0;
                end
            end
        end
    end

    assign si        = si_p1;
    assign sq        = sq_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_agc_quantize.sv
// Directed bench for agc_quantize with a 16-sample window (HI_LO=9, HI_HI=12, THR_INIT=16).
module tb_agc_quantize;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [7:0] i_in = 8'd0;
    logic [7:0] q_in = 8'd0;
    logic       thr_load = 1'b0;
    logic [6:0] thr_value = 7'd0;
    logic       freeze = 1'b0;
    logic [1:0] si, sq;
    logic       out_valid;
    logic [6:0] thr;
    logic [5:0] hi_count;
    logic       window_done;

    int n_cmp = 0;
    int n_err = 0;

    agc_quantize #(
        .WINDOW_LOG2(4), .HI_LO(9), .HI_HI(12), .THR_INIT(16), .THR_MIN(1), .THR_MAX(127)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .i_in(i_in), .q_in(q_in),
        .thr_load(thr_load), .thr_value(thr_value), .freeze(freeze),
        .si(si), .sq(sq), .out_valid(out_valid), .thr(thr),
        .hi_count(hi_count), .window_done(window_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic [7:0] i, input logic [7:0] q,
                        input logic ld, input logic [6:0] v);
        @(negedge clk);
        en = e; i_in = i; q_in = q; thr_load = ld; thr_value = v;
        @(posedge clk);
        #1;
        thr_load = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; en = 1'b0;
        #1;
        chk("async_rst_thr", 32'(thr), 32'd16);
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One 16-sample window: the first nboth samples are high on I and Q, the next nionly on I only.
    task automatic run_win(input int nboth, input int nionly, input logic [7:0] hv,
                           output logic [1:0] first_si);
        first_si = 2'b00;
        for (int k = 0; k < 16; k++) begin
            step(1'b1, (k < nboth + nionly) ? hv : 8'd0, (k < nboth) ? hv : 8'd0, 1'b0, 7'd0);
            if (k == 0) first_si = si;
            chk((k < 15) ? "wd_mid" : "wd_end", 32'(window_done), (k < 15) ? 32'd0 : 32'd1);
        end
    endtask

    logic [1:0] fs;
    int         exp_thr;

    initial begin
        // Reset state
        do_reset();
        chk("rst_si", 32'(si), 32'd0);
        chk("rst_sq", 32'(sq), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_thr", 32'(thr), 32'd16);
        chk("rst_hi", 32'(hi_count), 32'd0);
        chk("rst_wd", 32'(window_done), 32'd0);

        // Quantizer decisions at threshold 16
        step(1'b1, 8'd15, 8'd0, 1'b0, 7'd0);
        chk("q15_si", 32'(si), 32'd0);
        chk("q15_sq", 32'(sq), 32'd0);
        chk("q15_valid", 32'(out_valid), 32'd1);
        step(1'b1, 8'd16, 8'd0, 1'b0, 7'd0);
        chk("q16_si", 32'(si), 32'd1);
        step(1'b1, 8'hFF, 8'd0, 1'b0, 7'd0);
        chk("qm1_si", 32'(si), 32'd2);
        step(1'b1, 8'h80, 8'h80, 1'b0, 7'd0);
        chk("qm128_si", 32'(si), 32'd3);
        chk("qm128_sq", 32'(sq), 32'd3);
        step(1'b0, 8'd0, 8'd0, 1'b0, 7'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_hold_si", 32'(si), 32'd3);

        // Reset mid-window: no partial hi_count
        do_reset();
        chk("midrst_hi", 32'(hi_count), 32'd0);
        chk("midrst_thr", 32'(thr), 32'd16);

        // Threshold climb, then oscillation between 20 and 21
        run_win(16, 0, 8'd20, fs);
        chk("climb_hi", 32'(hi_count), 32'd32);
        chk("climb_thr", 32'(thr), 32'd17);
        for (int t = 18; t <= 21; t++) begin
            run_win(16, 0, 8'd20, fs);
            chk("climb_thr_n", 32'(thr), 32'(t));
        end
        step(1'b0, 8'd0, 8'd0, 1'b0, 7'd0);
        chk("wd_one_cycle", 32'(window_done), 32'd0);
        run_win(16, 0, 8'd20, fs);
        chk("osc_first_si", 32'(fs), 32'd0);
        chk("osc_hi0", 32'(hi_count), 32'd0);
        chk("osc_thr20", 32'(thr), 32'd20);
        run_win(16, 0, 8'd20, fs);
        chk("osc_first_si20", 32'(fs), 32'd1);
        chk("osc_thr21", 32'(thr), 32'd21);

        // Zero input: step down to THR_MIN and hold
        exp_thr = 21;
        for (int w = 0; w < 22; w++) begin
            run_win(0, 0, 8'd0, fs);
            if (exp_thr > 1) exp_thr--;
            chk("down_thr", 32'(thr), 32'(exp_thr));
        end

        // Band boundaries at threshold 16
        step(1'b0, 8'd0, 8'd0, 1'b1, 7'd16);
        chk("load16", 32'(thr), 32'd16);
        run_win(5, 0, 8'd20, fs);
        chk("band10_hi", 32'(hi_count), 32'd10);
        chk("band10_thr", 32'(thr), 32'd16);
        run_win(6, 1, 8'd20, fs);
        chk("band13_thr", 32'(thr), 32'd17);
        run_win(4, 0, 8'd20, fs);
        chk("band8_thr", 32'(thr), 32'd16);
        run_win(4, 1, 8'd20, fs);
        chk("band9_thr", 32'(thr), 32'd16);
        run_win(6, 0, 8'd20, fs);
        chk("band12_thr", 32'(thr), 32'd16);

        // Freeze blocks only the threshold step
        freeze = 1'b1;
        for (int w = 0; w < 2; w++) begin
            run_win(16, 0, 8'd20, fs);
            chk("frz_hi", 32'(hi_count), 32'd32);
            chk("frz_thr", 32'(thr), 32'd16);
        end
        freeze = 1'b0;

        // thr_load mid-window with a sample in the same cycle
        for (int k = 0; k < 8; k++) step(1'b1, 8'd20, 8'd20, 1'b0, 7'd0);
        step(1'b1, 8'd20, 8'd20, 1'b1, 7'd100);
        chk("ld100_thr", 32'(thr), 32'd100);
        chk("ld100_si_old", 32'(si), 32'd1);
        chk("ld100_wd", 32'(window_done), 32'd0);
        run_win(16, 0, 8'd20, fs);
        chk("ld100_first_si", 32'(fs), 32'd0);
        chk("ld100_hi", 32'(hi_count), 32'd0);
        chk("ld100_thr_dn", 32'(thr), 32'd99);
        step(1'b0, 8'd0, 8'd0, 1'b1, 7'd0);
        chk("ld0_clamp", 32'(thr), 32'd1);

        // Load on the window-end edge discards that window
        for (int k = 0; k < 15; k++) step(1'b1, 8'd20, 8'd20, 1'b0, 7'd0);
        step(1'b1, 8'd20, 8'd20, 1'b1, 7'd50);
        chk("ldend_wd", 32'(window_done), 32'd0);
        chk("ldend_hi", 32'(hi_count), 32'd0);
        chk("ldend_thr", 32'(thr), 32'd50);
        run_win(16, 0, 8'd20, fs);
        chk("ldend_next_thr", 32'(thr), 32'd49);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
